// File: rtl/rice_residual_decoder.sv
// Rice residual decoder.
// Consumes a serial, MSB-first Rice-coded bitstream for one partition (unary
// quotient terminated by a 1, followed by k remainder bits) and emits each
// zigzag-unmapped signed residual over a valid/ready handshake. A pulse on
// oDone marks the end of the partition; oError flags an escape parameter or
// a quotient longer than MAX_Q.

module rice_residual_decoder #(
    parameter int unsigned MAX_Q = 65535,
    parameter int unsigned CNT_W = 16
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic [3:0]       iParam,
    input  logic [CNT_W-1:0] iCount,
    input  logic             iBit,
    input  logic             iBitValid,
    output logic             oBitReady,
    output logic [31:0]      oResidual,
    output logic             oValid,
    input  logic             iReady,
    output logic             oDone,
    output logic             oError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNARY,
        S_BINARY,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      q_reg, q_next;
    // Only 13 remainder bits are ever stored: with k=14 the final bit goes
    // straight from the input into the unmapping path.
    logic [12:0]      r_reg, r_next;
    logic [3:0]       k_reg, k_next;
    logic [3:0]       bitcnt_reg, bitcnt_next;
    logic [CNT_W-1:0] remain_reg, remain_next;
    logic [31:0]      residual_reg, residual_next;
    logic             error_reg, error_next;

    // Remainder including the bit on the input this cycle.
    logic [13:0]      r_shift;
    // Folded codeword value u for the two ways a codeword can complete.
    logic [31:0]      u_binary;
    logic [31:0]      u_sel;
    // Signed residual recovered from u.
    logic [31:0]      unmapped;

    assign r_shift  = {r_reg, iBit};
    assign u_binary = (q_reg << k_reg) | {18'd0, r_shift};
    // With k==0 the codeword ends in the unary phase and u is just q.
    assign u_sel    = (state_reg == S_BINARY) ? u_binary : q_reg;

    // Zigzag unmap: (u >> 1) ^ -(u & 1). Bit 31 of (u >> 1) is always zero,
    // so the top result bit is the sign (u odd -> negative).
    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_unmap
            assign unmapped[gi] = u_sel[gi + 1] ^ u_sel[0];
        end
    endgenerate
    assign unmapped[31] = u_sel[0];

    assign oResidual = residual_reg;
    assign oError    = error_reg;

    // Control state register.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: quotient, remainder, counters, residual and error flag.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            q_reg        <= '0;
            r_reg        <= '0;
            k_reg        <= '0;
            bitcnt_reg   <= '0;
            remain_reg   <= '0;
            residual_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            q_reg        <= q_next;
            r_reg        <= r_next;
            k_reg        <= k_next;
            bitcnt_reg   <= bitcnt_next;
            remain_reg   <= remain_next;
            residual_reg <= residual_next;
            error_reg    <= error_next;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        r_next        = r_reg;
        k_next        = k_reg;
        bitcnt_next   = bitcnt_reg;
        remain_next   = remain_reg;
        residual_next = residual_reg;
        error_next    = error_reg;
        oBitReady     = 1'b0;
        oValid        = 1'b0;
        oDone         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (iStart) begin
                    k_next      = iParam;
                    remain_next = iCount;
                    error_next  = 1'b0;
                    q_next      = '0;
                    r_next      = '0;
                    bitcnt_next = '0;
                    if (iParam == 4'd15) begin
                        // Escape-coded partitions are not supported.
                        error_next = 1'b1;
                        state_next = S_DONE;
                    end else if (iCount == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_UNARY;
                    end
                end
            end

            S_UNARY: begin
                oBitReady = 1'b1;
                if (iBitValid) begin
                    if (!iBit) begin
                        if (q_reg == MAX_Q) begin
                            // One more zero would exceed the legal quotient.
                            error_next = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            q_next = q_reg + 32'd1;
                        end
                    end else if (k_reg == 4'd0) begin
                        residual_next = unmapped;
                        state_next    = S_EMIT;
                    end else begin
                        bitcnt_next = k_reg - 4'd1;
                        state_next  = S_BINARY;
                    end
                end
            end

            S_BINARY: begin
                oBitReady = 1'b1;
                if (iBitValid) begin
                    r_next = r_shift[12:0];
                    if (bitcnt_reg == 4'd0) begin
                        residual_next = unmapped;
                        state_next    = S_EMIT;
                    end else begin
                        bitcnt_next = bitcnt_reg - 4'd1;
                    end
                end
            end

            S_EMIT: begin
                oValid = 1'b1;
                if (iReady) begin
                    remain_next = remain_reg - 1'b1;
                    q_next      = '0;
                    r_next      = '0;
                    if (remain_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_UNARY;
                    end
                end
            end

            S_DONE: begin
                oDone      = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rice_residual_decoder.sv
// Scoreboard bench for rice_residual_decoder: partitions are generated from
// (q, r) pairs, expected residuals come from plain integer arithmetic, and a
// monitor process checks every accepted residual and every done pulse.

module tb_rice_residual_decoder;

    localparam int MAX_Q = 4;
    localparam int CNT_W = 16;

    logic             iClock    = 1'b0;
    logic             iReset_n  = 1'b0;
    logic             iStart    = 1'b0;
    logic [3:0]       iParam    = '0;
    logic [CNT_W-1:0] iCount    = '0;
    logic             iBit      = 1'b0;
    logic             iBitValid = 1'b0;
    logic             iReady    = 1'b0;
    logic             oBitReady;
    logic [31:0]      oResidual;
    logic             oValid;
    logic             oDone;
    logic             oError;

    rice_residual_decoder #(
        .MAX_Q(MAX_Q),
        .CNT_W(CNT_W)
    ) dut (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .iStart   (iStart),
        .iParam   (iParam),
        .iCount   (iCount),
        .iBit     (iBit),
        .iBitValid(iBitValid),
        .oBitReady(oBitReady),
        .oResidual(oResidual),
        .oValid   (oValid),
        .iReady   (iReady),
        .oDone    (oDone),
        .oError   (oError)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        bit is_done;
        int val;
        bit err;
    } exp_t;

    exp_t sb[$];
    bit   bitq[$];
    int   part_q[$];
    int   part_r[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_force = 0;
    int   txn = 0;

    // Signed residual from quotient, remainder and k, straight from the
    // folding rule: u = q*2^k + r; even u -> u/2, odd u -> -(u+1)/2.
    function automatic int ref_residual(input int q, input int r, input int k);
        longint u;
        u = longint'(q) * (longint'(1) << k) + longint'(r);
        if (u % 2 == 0) return int'(u / 2);
        return int'(-((u + 1) / 2));
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Build the bitstream and expectations for one partition and pulse iStart.
    task automatic issue(input int k, input int n);
        exp_t e;
        bit   err;
        err = 0;
        @(posedge iClock);
        #2;
        bitq.delete();
        if (k == 15) begin
            err = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (part_q[i] > MAX_Q) begin
                    for (int z = 0; z <= MAX_Q; z++) bitq.push_back(1'b0);
                    err = 1;
                    break;
                end
                for (int z = 0; z < part_q[i]; z++) bitq.push_back(1'b0);
                bitq.push_back(1'b1);
                for (int b = k - 1; b >= 0; b--) bitq.push_back(((part_r[i] >> b) & 1) != 0);
                e.is_done = 0;
                e.val     = ref_residual(part_q[i], part_r[i], k);
                e.err     = 0;
                sb.push_back(e);
            end
        end
        e.is_done = 1;
        e.val     = 0;
        e.err     = err;
        sb.push_back(e);
        iParam = 4'(k);
        iCount = CNT_W'(n);
        iStart = 1'b1;
        @(posedge iClock);
        #2;
        iStart = 1'b0;
    endtask

    // Wait until every expected item has been observed, with a cycle budget.
    task automatic wait_idle();
        int cyc;
        cyc = 0;
        checks++;
        while (sb.size() != 0) begin
            @(posedge iClock);
            cyc++;
            if (cyc > 4000) begin
                errors++;
                $display("FAIL timeout: %0d expected items pending, required 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic random_part();
        int k;
        int n;
        int q;
        k = ($urandom_range(0, 11) == 0) ? 15 : int'($urandom_range(0, 14));
        n = int'($urandom_range(0, 5));
        part_q.delete();
        part_r.delete();
        for (int i = 0; i < n; i++) begin
            q = ($urandom_range(0, 9) == 0) ? MAX_Q + 1 : int'($urandom_range(0, MAX_Q));
            part_q.push_back(q);
            part_r.push_back((k == 15) ? 0 : int'($urandom_range(0, (1 << k) - 1)));
        end
        issue(k, n);
    endtask

    // Bit feeder: presents the head of bitq with random stalls and pops it
    // once the decoder has taken it.
    initial begin
        bit xfer;
        forever begin
            @(negedge iClock);
            xfer = iBitValid && oBitReady;
            @(posedge iClock);
            #1;
            if (xfer && bitq.size() > 0) void'(bitq.pop_front());
            if (bitq.size() > 0 && $urandom_range(0, 3) != 0) begin
                iBitValid = 1'b1;
                iBit      = bitq[0];
            end else begin
                iBitValid = 1'b0;
                iBit      = 1'b0;
            end
        end
    end

    // Downstream ready: random, or forced low/high for directed backpressure.
    initial begin
        forever begin
            @(posedge iClock);
            #1;
            case (ready_force)
                1:       iReady = 1'b0;
                2:       iReady = 1'b1;
                default: iReady = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted residual and done pulse.
    initial begin
        exp_t        e;
        bit          prev_hold;
        logic [31:0] prev_res;
        prev_hold = 0;
        prev_res  = '0;
        forever begin
            @(negedge iClock);
            if (!iReset_n) begin
                prev_hold = 0;
            end else begin
                if (oValid && oDone) chk("valid_with_done", 1, 0);
                if (oValid) begin
                    chk("bitready_in_emit", longint'(oBitReady), 0);
                    if (prev_hold) chk("residual_held", longint'($signed(oResidual)), longint'($signed(prev_res)));
                    if (iReady) begin
                        prev_hold = 0;
                        if (sb.size() == 0 || sb[0].is_done) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_valid: got residual %0d, required no residual", $signed(oResidual));
                        end else begin
                            e = sb.pop_front();
                            txn++;
                            $display("txn %0d: residual %0d (expected %0d)", txn, $signed(oResidual), e.val);
                            chk("residual", longint'($signed(oResidual)), longint'(e.val));
                        end
                    end else begin
                        prev_hold = 1;
                        prev_res  = oResidual;
                    end
                end else begin
                    prev_hold = 0;
                end
                if (oDone) begin
                    if (sb.size() == 0 || !sb[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done with %0d residuals pending, required residual first", sb.size());
                    end else begin
                        e = sb.pop_front();
                        txn++;
                        $display("txn %0d: done error=%0d (expected %0d)", txn, oError, e.err);
                        chk("done_error", longint'(oError), longint'(e.err));
                    end
                end
            end
        end
    end

    // Main sequence: reset, directed cases, random partitions, mid-run reset.
    initial begin
        int cyc;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        chk("reset_bitready", longint'(oBitReady), 0);
        chk("reset_valid", longint'(oValid), 0);
        chk("reset_done", longint'(oDone), 0);
        chk("reset_error", longint'(oError), 0);
        chk("reset_residual", longint'(oResidual), 0);
        iReset_n = 1'b1;

        // k=2, q=3, r=2 -> 7
        part_q = '{3};
        part_r = '{2};
        issue(2, 1);
        wait_idle();

        // k=0 quotients 0,1,2 -> 0,-1,1; a stray iStart mid-partition is ignored
        part_q = '{0, 1, 2};
        part_r = '{0, 0, 0};
        issue(0, 3);
        repeat (2) @(posedge iClock);
        #2;
        iParam = 4'd15;
        iCount = 16'd1;
        iStart = 1'b1;
        @(posedge iClock);
        #2;
        iStart = 1'b0;
        wait_idle();

        // k=14, q=0, r=16383 -> -8192
        part_q = '{0};
        part_r = '{16383};
        issue(14, 1);
        wait_idle();

        // Backpressure: residual 7 held while iReady stays low
        ready_force = 1;
        part_q = '{3};
        part_r = '{2};
        issue(2, 1);
        cyc = 0;
        @(negedge iClock);
        while (!oValid && cyc < 200) begin
            @(negedge iClock);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", longint'(oValid), 1);
            chk("bp_residual", longint'($signed(oResidual)), 7);
            chk("bp_bitready", longint'(oBitReady), 0);
            @(negedge iClock);
        end
        ready_force = 2;
        wait_idle();
        ready_force = 0;

        // Escape parameter
        part_q.delete();
        part_r.delete();
        issue(15, 3);
        wait_idle();
        @(negedge iClock);
        chk("escape_error_sticky", longint'(oError), 1);

        // Quotient overflow after one good residual
        part_q = '{1, MAX_Q + 1};
        part_r = '{5, 0};
        issue(3, 2);
        wait_idle();
        @(negedge iClock);
        chk("overflow_error_sticky", longint'(oError), 1);

        for (int p = 0; p < 120; p++) begin
            random_part();
            wait_idle();
        end

        // Reset in the middle of a remainder field
        part_q = '{3};
        part_r = '{2};
        issue(2, 1);
        wait_idle();
        @(posedge iClock);
        #2;
        bitq.delete();
        bitq = '{1'b1, 1'b1, 1'b0, 1'b1};
        iParam = 4'd8;
        iCount = 16'd4;
        iStart = 1'b1;
        @(posedge iClock);
        #2;
        iStart = 1'b0;
        cyc = 0;
        while (bitq.size() != 0 && cyc < 200) begin
            @(posedge iClock);
            cyc++;
        end
        repeat (3) @(negedge iClock);
        chk("midrun_bitready", longint'(oBitReady), 1);
        chk("midrun_residual", longint'($signed(oResidual)), 7);
        #2;
        iReset_n = 1'b0;
        sb.delete();
        bitq.delete();
        #1;
        chk("abort_bitready", longint'(oBitReady), 0);
        chk("abort_valid", longint'(oValid), 0);
        chk("abort_done", longint'(oDone), 0);
        chk("abort_error", longint'(oError), 0);
        chk("abort_residual", longint'(oResidual), 0);
        @(negedge iClock);
        iReset_n = 1'b1;

        part_q = '{3};
        part_r = '{2};
        issue(2, 1);
        wait_idle();

        repeat (3) @(posedge iClock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
